// File: rtl/move_buffer_scheduler.sv
// Queued-move ring buffer between the SPI command side and the DDA step timer.
// Accepts move records over valid/ready, dispatches them one at a time with a
// start pulse, retires them on the DDA done pulse, and handles halt/flush,
// overflow reporting and free-slot flow control.
module move_buffer_scheduler #(
    parameter int BUFFER_BITS = 2,
    parameter int DATA_W      = 64
) (
    input  logic                   CLK,
    input  logic                   resetn,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_dir,
    input  logic [DATA_W-1:0]      wr_duration,
    input  logic [DATA_W-1:0]      wr_increment,
    input  logic [DATA_W-1:0]      wr_incrementincrement,
    output logic                   dda_start,
    input  logic                   dda_done,
    output logic                   dda_abort,
    output logic                   move_dir,
    output logic [DATA_W-1:0]      move_duration,
    output logic [DATA_W-1:0]      move_increment,
    output logic [DATA_W-1:0]      move_incrementincrement,
    output logic                   move_active,
    input  logic                   halt,
    input  logic                   clear_flags,
    output logic                   buffer_dtr,
    output logic [BUFFER_BITS:0]   fill_count,
    output logic                   overflow,
    output logic [31:0]            moves_completed
);

    localparam int DEPTH   = 1 << BUFFER_BITS;
    localparam int PTR_W   = BUFFER_BITS + 1;
    localparam int ENTRY_W = 1 + 3 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t               state_reg;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W-1:0]     wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_next;
    logic [PTR_W-1:0]     fill_next;
    logic                 wr_ready_reg;
    logic                 buffer_dtr_reg;
    logic                 dda_start_reg;
    logic                 dda_abort_reg;
    logic                 move_active_reg;
    logic                 overflow_reg;
    logic [31:0]          moves_completed_reg;
    logic                 move_dir_reg;
    logic [DATA_W-1:0]    move_duration_reg;
    logic [DATA_W-1:0]    move_increment_reg;
    logic [DATA_W-1:0]    move_incrementincrement_reg;

    logic                 full;
    logic                 empty;
    logic                 do_write;
    logic                 do_pop;
    logic [ENTRY_W-1:0]   head;
    logic                 head_dir;
    logic [DATA_W-1:0]    head_duration;
    logic [DATA_W-1:0]    head_increment;
    logic [DATA_W-1:0]    head_incrementincrement;

    // Pointer arithmetic: the extra MSB distinguishes full from empty.
    always_comb begin
        full        = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                      (wr_ptr_reg[PTR_W-2:0] == rd_ptr_reg[PTR_W-2:0]);
        empty       = (wr_ptr_reg == rd_ptr_reg);
        // Halt discards any write presented in the same cycle.
        do_write    = wr_valid && wr_ready_reg && !halt;
        do_pop      = (state_reg == LOAD) && !halt;
        wr_ptr_next = wr_ptr_reg + PTR_W'(do_write);
        rd_ptr_next = halt ? wr_ptr_reg : (rd_ptr_reg + PTR_W'(do_pop));
        fill_next   = wr_ptr_next - rd_ptr_next;
    end

    // Head-of-queue entry, split into its fields for the LOAD decision.
    always_comb begin
        head                    = mem[rd_ptr_reg[BUFFER_BITS-1:0]];
        head_dir                = head[ENTRY_W-1];
        head_duration           = head[3*DATA_W-1 -: DATA_W];
        head_increment          = head[2*DATA_W-1 -: DATA_W];
        head_incrementincrement = head[DATA_W-1:0];
    end

    // Storage array: write port only, no reset so it maps onto RAM.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[wr_ptr_reg[BUFFER_BITS-1:0]] <= {wr_dir, wr_duration,
                                                 wr_increment, wr_incrementincrement};
        end
    end

    // Pointers, flow control, flags and the dispatch state machine.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_reg                   <= IDLE;
            wr_ptr_reg                  <= '0;
            rd_ptr_reg                  <= '0;
            wr_ready_reg                <= 1'b1;
            buffer_dtr_reg              <= 1'b1;
            dda_start_reg               <= 1'b0;
            dda_abort_reg               <= 1'b0;
            move_active_reg             <= 1'b0;
            overflow_reg                <= 1'b0;
            moves_completed_reg         <= '0;
            move_dir_reg                <= 1'b0;
            move_duration_reg           <= '0;
            move_increment_reg          <= '0;
            move_incrementincrement_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            // Registered from the next fill level, so it always reflects !full.
            wr_ready_reg   <= !halt && (fill_next != PTR_W'(DEPTH));
            buffer_dtr_reg <= !halt && (fill_next != PTR_W'(DEPTH));
            dda_start_reg  <= 1'b0;
            dda_abort_reg  <= 1'b0;

            // A write attempt against a full buffer sets the sticky flag;
            // the set takes priority over a same-cycle clear.
            if (wr_valid && full) begin
                overflow_reg <= 1'b1;
            end else if (clear_flags) begin
                overflow_reg <= 1'b0;
            end

            if (halt) begin
                // Flush: abort only if the DDA was actually handed a move.
                state_reg       <= IDLE;
                move_active_reg <= 1'b0;
                dda_abort_reg   <= (state_reg == START) || (state_reg == RUN);
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (!empty) begin
                            state_reg <= LOAD;
                        end
                    end
                    LOAD: begin
                        move_dir_reg                <= head_dir;
                        move_duration_reg           <= head_duration;
                        move_increment_reg          <= head_increment;
                        move_incrementincrement_reg <= head_incrementincrement;
                        if (head_duration == '0) begin
                            // Zero-length move: retire without involving the DDA.
                            moves_completed_reg <= moves_completed_reg + 32'd1;
                            state_reg           <= IDLE;
                        end else begin
                            dda_start_reg   <= 1'b1;
                            move_active_reg <= 1'b1;
                            state_reg       <= START;
                        end
                    end
                    START: begin
                        state_reg <= RUN;
                    end
                    RUN: begin
                        if (dda_done) begin
                            move_active_reg     <= 1'b0;
                            moves_completed_reg <= moves_completed_reg + 32'd1;
                            // A write landing this cycle counts toward the next dispatch.
                            state_reg <= (wr_ptr_next != rd_ptr_reg) ? LOAD : IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign wr_ready                = wr_ready_reg;
    assign buffer_dtr              = buffer_dtr_reg;
    assign fill_count              = wr_ptr_reg - rd_ptr_reg;
    assign dda_start               = dda_start_reg;
    assign dda_abort               = dda_abort_reg;
    assign move_active             = move_active_reg;
    assign overflow                = overflow_reg;
    assign moves_completed         = moves_completed_reg;
    assign move_dir                = move_dir_reg;
    assign move_duration           = move_duration_reg;
    assign move_increment          = move_increment_reg;
    assign move_incrementincrement = move_incrementincrement_reg;

endmodule
